multiexp_feeder: RTL and testbench
==================================

MULTIEXP_FEEDER -- requirements
Module: multiexp_feeder

Interface
REQ-001 The module SHALL have parameter FP_TYPE, no default, the point type carried on each beat.
REQ-002 The module SHALL have parameter FE_TYPE, no default, the scalar type carried on each beat.
REQ-003 The module SHALL have parameter KEY_BITS, no default, the scalar bit count, equal to the number of replay passes.
REQ-004 The module SHALL have parameter CTL_BITS, no default, the width of the ctl field.
REQ-005 The module SHALL have parameter MAX_IN, default 1024, the pair buffer depth.
REQ-006 The module SHALL have port i_clk, input, 1 bit, the single clock.
REQ-007 The module SHALL have port i_rst_n, input, 1 bit, a synchronous active-low reset.
REQ-008 The module SHALL have port i_ld_if, if_axi_stream.sink, DAT {FP_TYPE,FE_TYPE}, the pair load stream, where eop marks the last pair.
REQ-009 The module SHALL have port o_pnt_scl_if, if_axi_stream.source, same DAT, the looping pair stream to the multiexp core.
REQ-010 The module SHALL have port o_num_in, output, 64 bits, the loaded pair count, which drives the core's i_num_in.
REQ-011 The module SHALL have port o_busy, output, 1 bit, high from the first load beat until the final replay beat is accepted.
REQ-012 The module SHALL have port o_done, output, 1 bit, a one-cycle pulse after the last replay beat is accepted.
REQ-013 The module SHALL have port o_ovf, output, 1 bit, a sticky flag set when a load exceeds MAX_IN pairs.

Function
REQ-014 The FSM SHALL use exactly three states, IDLE, LOAD and PLAY.
REQ-015 In IDLE, i_ld_if.rdy SHALL be 1, and the first accepted beat SHALL be written at address 0, latch ctl[CTL_BITS-1:1], and move the FSM to LOAD (or to PLAY if that beat has eop=1).
REQ-016 In LOAD, each accepted beat SHALL be written at wr_cnt, and o_num_in SHALL equal the number of pairs written.
REQ-017 LOAD SHALL end when a beat with eop=1 is accepted, giving PLAY on the next cycle.
REQ-018 If MAX_IN beats are written without eop, the following beats SHALL be accepted and dropped until eop, o_ovf SHALL be set, and o_num_in SHALL stay MAX_IN.
REQ-019 In PLAY, i_ld_if.rdy SHALL be 0, and the buffer SHALL be replayed addresses 0..o_num_in-1, exactly KEY_BITS times, in order.
REQ-020 Each replay beat SHALL have ctl[0]=0 (normal mode) and ctl[CTL_BITS-1:1] equal to the latched value.
REQ-021 Each replay beat SHALL have sop=1 on address 0 and eop=1 on address o_num_in-1, once per pass.
REQ-022 Output handshake: val SHALL hold with dat/ctl stable until rdy=1, and no beat SHALL be dropped or duplicated under arbitrary rdy toggling.
REQ-023 A 1-cycle buffer read latency SHALL be hidden by prefetch, so that with rdy held at 1 the output sustains one beat per cycle after the first.
REQ-024 The first PLAY beat SHALL present val=1 no later than 2 cycles after LOAD ends.
REQ-025 On acceptance of beat (pass KEY_BITS-1, address o_num_in-1), the FSM SHALL go to IDLE, o_done SHALL pulse on the next cycle, and o_busy SHALL drop on that same cycle.
REQ-026 When o_num_in=1, every beat SHALL carry sop=eop=1, and KEY_BITS beats SHALL be emitted.
REQ-027 Pass and address counters SHALL wrap only as specified, and the pass counter width SHALL be $clog2(KEY_BITS)+1.

Reset
REQ-028 While i_rst_n=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-029 The same reset SHALL clear all counters, o_num_in=0, o_busy=0, o_done=0, o_ovf=0, o_pnt_scl_if.val=0, sop/eop=0 and i_ld_if.rdy=0, with rdy rising to 1 on the first cycle after release.
REQ-030 Reset mid-LOAD or mid-PLAY SHALL abandon the operation, and buffer contents SHALL NOT be cleared and SHALL NOT be reused.

Configuration
REQ-031 When macro MULTIEXP_FEEDER_OUT_SKID_EN is defined, a 2-entry skid buffer SHALL register o_pnt_scl_if, making every output flop-driven, with rdy registered and REQ-024 latency becoming 3 cycles.
REQ-032 Without MULTIEXP_FEEDER_OUT_SKID_EN, the output SHALL be driven directly from the prefetch stage, with identical beat ordering in both builds.

Structure
REQ-033 The FSM state enum and a MULTIEXP_FEEDER_DEPTH default SHALL reside in the shared multiexp package, alongside the curve FP_TYPE/FE_TYPE typedefs already there.
REQ-034 Pair storage SHALL be one sub-module, multiexp_feeder_ram: simple dual-port, 1 write port, 1 read port, 1-cycle registered read, MAX_IN x $bits({FP_TYPE,FE_TYPE}).

Verification
REQ-035 Load 4 pairs with KEY_BITS=3 and rdy=1 constantly -> o_num_in=4, 12 beats in order 0,1,2,3 x3, sop at 0, eop at 3, then o_done one pulse.
REQ-036 Same load with rdy driven by a random 30% duty -> identical 12-beat sequence, with no val drop while rdy=0.
REQ-037 With MAX_IN=8, load 11 beats with eop on the 11th -> o_ovf=1, o_num_in=8, and only the first 8 pairs replayed.
REQ-038 Load a single pair with KEY_BITS=4 -> 4 beats, each with sop=eop=1 and ctl[0]=0.
REQ-039 Assert i_rst_n=0 during pass 1 beat 2 -> next cycle val=0, busy=0, rdy=1, and a fresh 2-pair load replays correctly.
REQ-040 Feed the output into multiexp_core with scalars {1,2} and points {G,G} -> core result equals 3G, run under both macro settings.

Source files
------------

// File: rtl/multiexp_feeder_pkg.sv
// Shared multiexp types: curve point/scalar typedefs, feeder depth and FSM state codes.
package multiexp_feeder_pkg;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } fp_t;

  typedef logic [15:0] fe_t;

  localparam int MULTIEXP_FEEDER_DEPTH = 1024;

  // state | meaning
  // IDLE  | waiting for the first pair of a new load
  // LOAD  | writing pairs into the buffer until eop
  // PLAY  | replaying the buffer KEY_BITS times to the core
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;

endpackage

// File: rtl/multiexp_feeder_if.sv
// Valid/ready beat stream with sop/eop framing and a ctl sideband.
interface multiexp_feeder_if #(
  parameter int DAT_BITS = 48,
  parameter int CTL_BITS = 4
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;

  modport source (output val, sop, eop, dat, ctl, input rdy);
  modport sink   (input val, sop, eop, dat, ctl, output rdy);
  modport master (output val, sop, eop, dat, ctl, input rdy);
  modport slave  (input val, sop, eop, dat, ctl, output rdy);
endinterface

// File: rtl/multiexp_feeder_ram.sv
// Simple dual-port pair buffer: one write port, one read port with a registered read.
module multiexp_feeder_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 48,
  parameter int AW    = 10
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_dat
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_dat;
    // rd data holds while no read is issued, so a stalled beat stays stable
    if (i_rd_en) o_rd_dat <= mem[i_rd_addr];
  end
endmodule

// File: rtl/multiexp_feeder.sv
// Buffers a (point, scalar) load and replays it KEY_BITS times to the multiexp core.
// Optional MULTIEXP_FEEDER_OUT_SKID_EN adds a 2-entry registered skid on the output.
module multiexp_feeder
  import multiexp_feeder_pkg::*;
#(
  parameter type FP_TYPE  = fp_t,
  parameter type FE_TYPE  = fe_t,
  parameter int  KEY_BITS = 4,
  parameter int  CTL_BITS = 4,
  parameter int  MAX_IN   = MULTIEXP_FEEDER_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  multiexp_feeder_if.sink   i_ld_if,
  multiexp_feeder_if.source o_pnt_scl_if,
  output logic [63:0]       o_num_in,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf
);
  localparam int DAT_BITS = $bits(FP_TYPE) + $bits(FE_TYPE);
  localparam int AW       = (MAX_IN > 1) ? $clog2(MAX_IN) : 1;
  localparam int PW       = $clog2(KEY_BITS) + 1;
  localparam logic [AW:0]   MAX_CNT   = MAX_IN[AW:0];
  localparam logic [PW-1:0] LAST_PASS = PW'(KEY_BITS - 1);

  logic [1:0]          state, state_nxt;
  logic                ld_rdy, busy, done, ovf;
  logic [AW:0]         wr_cnt;
  logic [CTL_BITS-2:0] ctl_hi;
  logic [AW-1:0]       rd_addr, wr_addr;
  logic [PW-1:0]       rd_pass;
  logic                all_issued;
  logic [DAT_BITS-1:0] ram_rdat;
  logic                p_val, p_rdy, p_sop, p_eop, p_last;
  logic                x_val, x_sop, x_eop, x_last;
  logic [DAT_BITS-1:0] x_dat;
  logic                ld_acc, wr_en, issue, rd_is_eop, final_acc;
  logic                unused_ld;

  assign unused_ld = ^{i_ld_if.sop, i_ld_if.ctl[0]};

  assign ld_acc    = i_ld_if.val && ld_rdy;
  assign wr_en     = ld_acc && ((state == ST_IDLE) || (wr_cnt < MAX_CNT));
  assign wr_addr   = (state == ST_IDLE) ? '0 : wr_cnt[AW-1:0];
  assign rd_is_eop = ({1'b0, rd_addr} == (wr_cnt - 1'b1));
  assign issue     = (state == ST_PLAY) && !all_issued && (!p_val || p_rdy);
  assign final_acc = x_val && o_pnt_scl_if.rdy && x_last;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (ld_acc) state_nxt = i_ld_if.eop ? ST_PLAY : ST_LOAD;
      ST_LOAD: if (ld_acc && i_ld_if.eop) state_nxt = ST_PLAY;
      ST_PLAY: if (final_acc) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      ld_rdy     <= 1'b0;
      wr_cnt     <= '0;
      ctl_hi     <= '0;
      rd_addr    <= '0;
      rd_pass    <= '0;
      all_issued <= 1'b0;
      p_val      <= 1'b0;
      p_sop      <= 1'b0;
      p_eop      <= 1'b0;
      p_last     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state  <= state_nxt;
      ld_rdy <= (state_nxt != ST_PLAY);
      done   <= final_acc;
      if (state == ST_IDLE && ld_acc) begin
        wr_cnt <= {{AW{1'b0}}, 1'b1};
        ctl_hi <= i_ld_if.ctl[CTL_BITS-1:1];
        busy   <= 1'b1;
      end else if (state == ST_LOAD && ld_acc) begin
        // past MAX_IN pairs the beats are swallowed until eop
        if (wr_en) wr_cnt <= wr_cnt + 1'b1;
        else       ovf    <= 1'b1;
      end
      if (final_acc) busy <= 1'b0;
      if (state != ST_PLAY) begin
        rd_addr    <= '0;
        rd_pass    <= '0;
        all_issued <= 1'b0;
      end else if (issue) begin
        if (rd_is_eop) begin
          rd_addr <= '0;
          rd_pass <= rd_pass + 1'b1;
          if (rd_pass == LAST_PASS) all_issued <= 1'b1;
        end else begin
          rd_addr <= rd_addr + 1'b1;
        end
      end
      // RAM output register doubles as the prefetch stage; its flags ride alongside
      if (issue) begin
        p_val  <= 1'b1;
        p_sop  <= (rd_addr == '0);
        p_eop  <= rd_is_eop;
        p_last <= rd_is_eop && (rd_pass == LAST_PASS);
      end else if (p_rdy) begin
        p_val <= 1'b0;
      end
    end
  end

  multiexp_feeder_ram #(.DEPTH(MAX_IN), .WIDTH(DAT_BITS), .AW(AW)) u_ram (
    .i_clk    (i_clk),
    .i_wr_en  (wr_en),
    .i_wr_addr(wr_addr),
    .i_wr_dat (i_ld_if.dat),
    .i_rd_en  (issue),
    .i_rd_addr(rd_addr),
    .o_rd_dat (ram_rdat)
  );

`ifdef MULTIEXP_FEEDER_OUT_SKID_EN
  logic                sk_val, sk_sop, sk_eop, sk_last;
  logic [DAT_BITS-1:0] sk_dat;

  assign p_rdy = !sk_val;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      x_val   <= 1'b0;
      x_sop   <= 1'b0;
      x_eop   <= 1'b0;
      x_last  <= 1'b0;
      x_dat   <= '0;
      sk_val  <= 1'b0;
      sk_sop  <= 1'b0;
      sk_eop  <= 1'b0;
      sk_last <= 1'b0;
      sk_dat  <= '0;
    end else if (!x_val || o_pnt_scl_if.rdy) begin
      if (sk_val) begin
        x_val  <= 1'b1;
        x_sop  <= sk_sop;
        x_eop  <= sk_eop;
        x_last <= sk_last;
        x_dat  <= sk_dat;
        sk_val <= 1'b0;
      end else begin
        x_val  <= p_val;
        x_sop  <= p_sop;
        x_eop  <= p_eop;
        x_last <= p_last;
        x_dat  <= ram_rdat;
      end
    end else if (p_val && p_rdy) begin
      sk_val  <= 1'b1;
      sk_sop  <= p_sop;
      sk_eop  <= p_eop;
      sk_last <= p_last;
      sk_dat  <= ram_rdat;
    end
  end
`else
  assign p_rdy  = o_pnt_scl_if.rdy;
  assign x_val  = p_val;
  assign x_sop  = p_sop;
  assign x_eop  = p_eop;
  assign x_last = p_last;
  assign x_dat  = ram_rdat;
`endif

  assign i_ld_if.rdy      = ld_rdy;
  assign o_pnt_scl_if.val = x_val;
  assign o_pnt_scl_if.sop = x_sop;
  assign o_pnt_scl_if.eop = x_eop;
  assign o_pnt_scl_if.dat = x_dat;
  assign o_pnt_scl_if.ctl = {ctl_hi, 1'b0};
  assign o_num_in         = 64'(wr_cnt);
  assign o_busy           = busy;
  assign o_done           = done;
  assign o_ovf            = ovf;
endmodule

// File: tb/tb_multiexp_feeder.sv
// Self-checking bench for multiexp_feeder: table vectors, random loads and a mid-replay reset.
module tb_multiexp_feeder;
  import multiexp_feeder_pkg::*;

  localparam int DW   = $bits(fp_t) + $bits(fe_t);
  localparam int KB   = 3;
  localparam int CB   = 4;
  localparam int MAXN = 8;
`ifdef MULTIEXP_FEEDER_OUT_SKID_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int          n;
    int          pct;
    logic [3:0]  ctl;
    logic [63:0] exp_num;
    logic        exp_ovf;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        rst_n;
  logic [63:0] o_num_in;
  logic        o_busy, o_done, o_ovf;
  int          checks = 0;
  int          failures = 0;
  logic [DW-1:0]         pairs [16];
  logic [DW+CB+1:0]      exp_q [$];
  vec_t                  tbl [6];

  multiexp_feeder_if #(.DAT_BITS(DW), .CTL_BITS(CB)) ld_if ();
  multiexp_feeder_if #(.DAT_BITS(DW), .CTL_BITS(CB)) out_if ();

  multiexp_feeder #(
    .FP_TYPE(fp_t), .FE_TYPE(fe_t), .KEY_BITS(KB), .CTL_BITS(CB), .MAX_IN(MAXN)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (rst_n),
    .i_ld_if     (ld_if),
    .o_pnt_scl_if(out_if),
    .o_num_in    (o_num_in),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_ovf       (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ld_if.val = 1'b0;
    out_if.rdy = 1'b0;
    repeat (2) @(negedge i_clk);
    rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic fill_pairs();
    for (int i = 0; i < 16; i++) pairs[i] = DW'({$urandom, $urandom});
  endtask

  // Expected replay: the first min(n, MAXN) pairs, KB passes, framed per pass.
  task automatic build_exp(input int n, input logic [3:0] c);
    int m;
    m = (n > MAXN) ? MAXN : n;
    exp_q.delete();
    for (int p = 0; p < KB; p++)
      for (int a = 0; a < m; a++)
        exp_q.push_back({a == 0, a == m - 1, c[3:1], 1'b0, pairs[a]});
  endtask

  task automatic load(input int n, input logic [3:0] c, input bit gaps);
    int w;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        ld_if.val = 1'b0;
        @(negedge i_clk);
      end
      ld_if.val = 1'b1;
      ld_if.dat = pairs[i];
      ld_if.sop = (i == 0);
      ld_if.eop = (i == n - 1);
      ld_if.ctl = c;
      w = 0;
      while (!ld_if.rdy && w < 50) begin
        @(negedge i_clk);
        w++;
      end
      if (w >= 50) begin
        checks++;
        failures++;
        $display("FAIL load_timeout beat=%0d rdy=%0b required=1", i, ld_if.rdy);
      end
      @(negedge i_clk);
    end
    ld_if.val = 1'b0;
    ld_if.eop = 1'b0;
  endtask

  task automatic run_play(input int pct, input int abort_at, output bit aborted);
    int cyc, popped, first;
    bit pv, pr, fin;
    logic [DW+CB+1:0] pb, now, e;
    cyc = 0; popped = 0; first = -1; pv = 0; pr = 0; fin = 0; pb = '0;
    aborted = 0;
    while (!fin && cyc < 600) begin
      cyc++;
      now = {out_if.sop, out_if.eop, out_if.ctl, out_if.dat};
      if (out_if.val && first < 0) begin
        first = cyc;
        chk("first_val_latency_ok", 64'(first <= LAT), 1);
        chk("busy_in_play", o_busy, 1);
      end
      if (pv && !pr) chk("hold_stable", {out_if.val, now}, {1'b1, pb});
      if (o_done) begin
        chk("beats_left_at_done", exp_q.size(), 0);
        chk("busy_at_done", o_busy, 0);
        fin = 1;
      end else begin
        if (abort_at >= 0 && popped == abort_at && out_if.val) begin
          rst_n = 1'b0;
          out_if.rdy = 1'b0;
          aborted = 1;
          return;
        end
        if (pct == 100 && first > 0 && exp_q.size() > 0) chk("no_gap", out_if.val, 1);
        out_if.rdy = ($urandom_range(0, 99) < pct);
        if (out_if.val && out_if.rdy) begin
          if (exp_q.size() == 0) chk("extra_beat", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("beat", now, e);
            popped++;
          end
        end
        pv = out_if.val;
        pr = out_if.rdy;
        pb = now;
        @(negedge i_clk);
      end
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL play_timeout popped=%0d left=%0d", popped, exp_q.size());
    end
    out_if.rdy = 1'b0;
    @(negedge i_clk);
    chk("done_one_pulse", o_done, 0);
    chk("ld_rdy_after_done", ld_if.rdy, 1);
  endtask

  task automatic run_vec(input int n, input int pct, input logic [3:0] c,
                         input logic [63:0] exp_num, input logic exp_ovf);
    bit ab;
    do_reset();
    fill_pairs();
    load(n, c, pct != 100);
    chk("num_in", o_num_in, exp_num);
    chk("ovf", o_ovf, exp_ovf);
    chk("ld_rdy_in_play", ld_if.rdy, 0);
    build_exp(n, c);
    run_play(pct, -1, ab);
  endtask

  initial begin
    bit ab;
    int n;
    rst_n = 1'b0;
    ld_if.val = 1'b0;
    ld_if.sop = 1'b0;
    ld_if.eop = 1'b0;
    ld_if.dat = '0;
    ld_if.ctl = '0;
    out_if.rdy = 1'b0;
    tbl[0] = '{n: 4,  pct: 100, ctl: 4'hB, exp_num: 64'd4, exp_ovf: 1'b0};
    tbl[1] = '{n: 4,  pct: 30,  ctl: 4'h6, exp_num: 64'd4, exp_ovf: 1'b0};
    tbl[2] = '{n: 1,  pct: 100, ctl: 4'hF, exp_num: 64'd1, exp_ovf: 1'b0};
    tbl[3] = '{n: 1,  pct: 40,  ctl: 4'h3, exp_num: 64'd1, exp_ovf: 1'b0};
    tbl[4] = '{n: 8,  pct: 100, ctl: 4'h9, exp_num: 64'd8, exp_ovf: 1'b0};
    tbl[5] = '{n: 11, pct: 50,  ctl: 4'hE, exp_num: 64'd8, exp_ovf: 1'b1};

    repeat (3) @(negedge i_clk);
    chk("rst_num_in", o_num_in, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_val", out_if.val, 0);
    chk("rst_sop_eop", {out_if.sop, out_if.eop}, 0);
    chk("rst_ld_rdy", ld_if.rdy, 0);
    rst_n = 1'b1;
    @(negedge i_clk);
    chk("ld_rdy_after_release", ld_if.rdy, 1);

    for (int v = 0; v < 6; v++)
      run_vec(tbl[v].n, tbl[v].pct, tbl[v].ctl, tbl[v].exp_num, tbl[v].exp_ovf);

    // reset during pass 1, beat 2, then a fresh 2-pair load
    do_reset();
    fill_pairs();
    load(4, 4'h5, 0);
    build_exp(4, 4'h5);
    run_play(100, 4 + 2, ab);
    chk("abort_reached", ab, 1);
    @(negedge i_clk);
    chk("abort_val", out_if.val, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    rst_n = 1'b1;
    @(negedge i_clk);
    chk("abort_ld_rdy", ld_if.rdy, 1);
    chk("abort_val_after", out_if.val, 0);
    fill_pairs();
    load(2, 4'hC, 0);
    chk("fresh_num_in", o_num_in, 2);
    build_exp(2, 4'hC);
    run_play(100, -1, ab);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      run_vec(n, $urandom_range(20, 100), 4'($urandom),
              64'((n > MAXN) ? MAXN : n), n > MAXN);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
